// File: rtl/pipe_add_sub.sv
// Two-stage carry-select add/subtract with valid/ready flow control.
// Define PIPE_ADD_SUB_SAT_EN to enable signed saturation when sat is set.
module pipe_add_sub #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NB = WIDTH / BLOCK;
    localparam logic [BLOCK:0] ONE = (BLOCK+1)'(1);
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef PIPE_ADD_SUB_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // stage 1 state
    logic             v1_q, v1_d;
    logic [WIDTH-1:0] bs0_q, bs0_d;
    logic [WIDTH-1:0] bs1_q, bs1_d;
    logic [NB-1:0]    gp_q, gp_d;
    logic [NB-1:0]    gg_q, gg_d;
    logic             sub1_q, sub1_d;
    logic             sat1_q, sat1_d;
    logic             as_q, as_d;
    logic             bs_q, bs_d;

    // stage 2 state
    logic             v2_q, v2_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             ld1, ld2;
    logic [WIDTH-1:0] bp;
    logic [BLOCK:0]   blk0, blk1;
    logic             c;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] fin;
    logic             of;

    // a register loads when empty or when its contents move on this cycle
    assign ld2      = !v2_q || out_ready;
    assign ld1      = !v1_q || ld2;
    assign in_ready = ld1;
    assign bp       = sub ? ~b : b;

    // stage 1: per-block sums for both carry-ins plus group P/G
    always_comb begin
        v1_d   = v1_q;
        bs0_d  = bs0_q;
        bs1_d  = bs1_q;
        gp_d   = gp_q;
        gg_d   = gg_q;
        sub1_d = sub1_q;
        sat1_d = sat1_q;
        as_d   = as_q;
        bs_d   = bs_q;
        blk0   = '0;
        blk1   = '0;
        if (ld1) begin
            v1_d = in_valid;
            if (in_valid) begin
                sub1_d = sub;
                sat1_d = sat;
                as_d   = a[WIDTH-1];
                bs_d   = bp[WIDTH-1];
                for (int i = 0; i < NB; i++) begin
                    blk0 = {1'b0, a[i*BLOCK +: BLOCK]}
                         + {1'b0, bp[i*BLOCK +: BLOCK]};
                    blk1 = blk0 + ONE;
                    bs0_d[i*BLOCK +: BLOCK] = blk0[BLOCK-1:0];
                    bs1_d[i*BLOCK +: BLOCK] = blk1[BLOCK-1:0];
                    gg_d[i] = blk0[BLOCK];
                    gp_d[i] = &(a[i*BLOCK +: BLOCK] ^ bp[i*BLOCK +: BLOCK]);
                end
            end
        end
    end

    // stage 2 datapath: block carries from group P/G, then select and flag
    always_comb begin
        c   = sub1_q;
        sum = '0;
        for (int i = 0; i < NB; i++) begin
            sum[i*BLOCK +: BLOCK] = c ? bs1_q[i*BLOCK +: BLOCK]
                                      : bs0_q[i*BLOCK +: BLOCK];
            c = gg_q[i] | (gp_q[i] & c);
        end
        of  = (as_q == bs_q) && (sum[WIDTH-1] != as_q);
        fin = sum;
        if (SAT_EN && sat1_q && of) begin
            fin = as_q ? SMIN : SMAX;
        end
    end

    // stage 2 register load control
    always_comb begin
        v2_d   = v2_q;
        s_d    = s_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (ld2) begin
            v2_d = v1_q;
            if (v1_q) begin
                s_d    = fin;
                cout_d = c;
                ovf_d  = of;
                zero_d = (fin == '0);
            end
        end
    end

    // pipeline registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v1_q   <= 1'b0;
            bs0_q  <= '0;
            bs1_q  <= '0;
            gp_q   <= '0;
            gg_q   <= '0;
            sub1_q <= 1'b0;
            sat1_q <= 1'b0;
            as_q   <= 1'b0;
            bs_q   <= 1'b0;
            v2_q   <= 1'b0;
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            bs0_q  <= bs0_d;
            bs1_q  <= bs1_d;
            gp_q   <= gp_d;
            gg_q   <= gg_d;
            sub1_q <= sub1_d;
            sat1_q <= sat1_d;
            as_q   <= as_d;
            bs_q   <= bs_d;
            v2_q   <= v2_d;
            s_q    <= s_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = v2_q;
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Directed bench for pipe_add_sub: 32/8 and 16/4 instances.
// Results are checked in order against a queue of expected values.
module tb_pipe_add_sub;

    typedef struct packed {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        sub, sat;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] s;
    logic        cout, ovf, zero;

    logic        iv16, ir16, ov16, or16;
    logic [15:0] a16, b16, s16;
    logic        sub16, sat16, co16, of16, z16;

    int   checks = 0;
    int   failures = 0;
    int   occ = 0;
    int   k = 0;
    int   ir_low = 0;
    bit   pend_in, pend_out;
    bit   or_pat_en = 1'b0;
    bit   or_fixed = 1'b1;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    pipe_add_sub #(.WIDTH(32), .BLOCK(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf), .zero(zero)
    );

    pipe_add_sub #(.WIDTH(16), .BLOCK(4)) dut16 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .sub(sub16), .sat(sat16),
        .out_valid(ov16), .out_ready(or16),
        .s(s16), .cout(co16), .ovf(of16), .zero(z16)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ex(input logic [31:0] es, input logic ec,
                                input logic eo, input logic ez);
        exp_t e;
        e.s = es; e.cout = ec; e.ovf = eo; e.zero = ez;
        return e;
    endfunction

    function automatic logic [31:0] pick(input logic [31:0] wrapped,
                                         input logic [31:0] clamped);
`ifdef PIPE_ADD_SUB_SAT_EN
        return clamped;
`else
        return wrapped;
`endif
    endfunction

    function automatic exp_t mdl(input logic [31:0] ma, input logic [31:0] mb);
        logic [32:0] r;
        r = {1'b0, ma} + {1'b0, mb};
        return ex(r[31:0], r[32],
                  (ma[31] == mb[31]) && (r[31] != ma[31]), r[31:0] == 0);
    endfunction

    // out_ready driver: fixed level or repeating 1,0,0 pattern
    initial begin
        forever begin
            @(posedge clock);
            #2;
            out_ready = or_pat_en ? (k % 3 == 0) : or_fixed;
            if (or_pat_en) k++;
        end
    end

    // monitor: in_ready rule and in-order result comparison
    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                occ = 0;
                pend_in = 0;
                pend_out = 0;
                check("rst_in_ready", in_ready, 1);
            end else begin
                pend_in  = in_valid && in_ready;
                pend_out = out_valid && out_ready;
                check("in_ready", in_ready, (occ < 2) || out_ready);
                if (!in_ready) ir_low++;
                if (pend_out) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out", out_valid, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("s", s, e.s);
                        check("cout", cout, e.cout);
                        check("ovf", ovf, e.ovf);
                        check("zero", zero, e.zero);
                    end
                end
            end
        end
    end

    // occupancy model update on the active edge
    initial begin
        forever begin
            @(posedge clock);
            if (reset_n) occ = occ + int'(pend_in) - int'(pend_out);
        end
    end

    task automatic send(input logic [31:0] ta, input logic [31:0] tb_,
                        input logic tsub, input logic tsat, input exp_t e);
        int n = 0;
        bit done = 0;
        in_valid = 1; a = ta; b = tb_; sub = tsub; sat = tsat;
        while (!done) begin
            @(negedge clock);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1;
            end
            @(posedge clock);
            #1;
            n++;
            if (!done && n > 50) begin
                check("send_timeout", n, 0);
                done = 1;
            end
        end
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clock);
            n++;
        end
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        reset_n = 0; in_valid = 0; a = 0; b = 0; sub = 0; sat = 0;
        iv16 = 0; a16 = 0; b16 = 0; sub16 = 0; sat16 = 0; or16 = 1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
        check("rst_flags", {cout, ovf, zero}, 0);
        check("rst_ready", in_ready, 1);
        repeat (2) @(posedge clock);
        #1 reset_n = 1;
        check("ready_after_rst", in_ready, 1);

        exp_q.push_back(ex(32'h0000_0100, 0, 0, 0));
        in_valid = 1; a = 32'h0000_00FF; b = 32'h0000_0001; sub = 0; sat = 0;
        @(posedge clock);
        #1 in_valid = 0;
        check("lat_cycle1", out_valid, 0);
        @(posedge clock);
        #1;
        check("lat_cycle2", out_valid, 1);
        drain();

        send(32'h7FFF_FFFF, 32'h1, 0, 1,
             ex(pick(32'h8000_0000, 32'h7FFF_FFFF), 0, 1, 0));
        send(32'h7FFF_FFFF, 32'h1, 0, 0, ex(32'h8000_0000, 0, 1, 0));
        send(32'h8000_0000, 32'hFFFF_FFFF, 0, 1,
             ex(pick(32'h7FFF_FFFF, 32'h8000_0000), 1, 1, 0));
        send(32'h8000_0000, 32'h1, 1, 1,
             ex(pick(32'h7FFF_FFFF, 32'h8000_0000), 1, 1, 0));
        send(32'h1, 32'h2, 0, 1, ex(32'h3, 0, 0, 0));
        send(32'h5, 32'h5, 1, 0, ex(32'h0, 1, 0, 1));
        send(32'h0, 32'h1, 1, 0, ex(32'hFFFF_FFFF, 0, 0, 0));
        send(32'hFFFF_FFFF, 32'h1, 0, 0, ex(32'h0, 1, 0, 1));
        send(32'h1234_5678, 32'h0F0F_0F0F, 0, 0, ex(32'h2143_6587, 0, 0, 0));
        send(32'h8000_0000, 32'h8000_0000, 0, 0, ex(32'h0, 1, 1, 1));
        drain();

        or_pat_en = 1;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] ta, tbv;
            ta  = 32'h1357_9BDF + i * 32'h2468_ACE0;
            tbv = 32'h0F0F_F0F0 ^ (i * 32'h0101_0101);
            send(ta, tbv, 0, 0, mdl(ta, tbv));
        end
        drain();
        check("stream_stalled", ir_low > 0, 1);
        or_pat_en = 0;
        or_fixed = 0;

        send(32'h1, 32'h1, 0, 0, ex(32'h2, 0, 0, 0));
        send(32'h2, 32'h2, 0, 0, ex(32'h4, 0, 0, 0));
        check("two_in_flight", out_valid, 1);
        reset_n = 0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_s", s, 0);
        check("midrst_flags", {cout, ovf, zero}, 0);
        check("midrst_ready", in_ready, 1);
        @(posedge clock);
        #1 reset_n = 1;
        or_fixed = 1;
        check("release_ready", in_ready, 1);
        repeat (5) @(posedge clock);
        #1;
        check("no_out_after_rst", out_valid, 0);

        iv16 = 1; a16 = 16'hFFFF; b16 = 16'h0001;
        check("w16_ready", ir16, 1);
        @(posedge clock);
        #1 a16 = 16'h7FFF; b16 = 16'h0001;
        @(posedge clock);
        #1 iv16 = 0;
        check("w16_valid", ov16, 1);
        check("w16_s", s16, 16'h0000);
        check("w16_flags", {co16, of16, z16}, 3'b101);
        @(posedge clock);
        #1;
        check("w16b_s", s16, 16'h8000);
        check("w16b_flags", {co16, of16, z16}, 3'b010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
